// File: rtl/sample_frame_packer.sv
// Buffers 32-bit samples in a small FIFO and emits paced frames (header, payload, XOR checksum)
// as data/address/write-strobe triples for a UART transmit wrapper without back-pressure.
module sample_frame_packer #(
  parameter int unsigned FRAME_LEN  = 8,
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned GAP_CYCLES = 50000,
  // Value the frame sequence number takes on reset
  parameter logic [15:0] SEQ_INIT   = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [31:0]       i_sample,
  output logic [31:0]       o_data,
  output logic [8:0]        o_addr,
  output logic              o_wr,
  output logic              o_busy,
  output logic [FIFO_AW:0]  o_level,
  output logic [15:0]       o_drop_cnt
);

  localparam int unsigned     Depth     = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DepthLvl = (FIFO_AW + 1)'(Depth);
  localparam logic [FIFO_AW:0] FrameLvl = (FIFO_AW + 1)'(FRAME_LEN);
  localparam logic [15:0]     GapReload = 16'(GAP_CYCLES - 1);
  localparam logic [8:0]      LastIdx   = 9'(FRAME_LEN - 1);
  localparam logic [8:0]      ChkAddr   = 9'(FRAME_LEN + 1);
  localparam logic [15:0]     HdrMagic  = 16'hA5A5;

  typedef enum logic [1:0] {StIdle, StHdr, StPay, StChk} state_e;

  state_e state_q, state_d;

  logic [31:0]      mem_q [Depth];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0] level;
  logic             full, push, drop, pop;
  logic [31:0]      head;
  logic [15:0]      drop_cnt_q;

  logic [31:0] data_q, data_d;
  logic [8:0]  addr_q, addr_d;
  logic        wr_q, strobe;
  logic [31:0] chk_q, chk_d;
  logic [8:0]  idx_q, idx_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] gap_q, gap_d;
  logic        gap_ok;

  // Full is judged on the pre-pop level, so a push while full is lost even if a pop coincides
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == DepthLvl);
  assign push  = i_valid && !full;
  assign drop  = i_valid && full;
  assign head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= i_sample;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    strobe  = 1'b0;
    pop     = 1'b0;
    data_d  = data_q;
    addr_d  = addr_q;
    chk_d   = chk_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    gap_ok  = (gap_q == 16'd0);

    unique case (state_q)
      StIdle: begin
        // The whole payload must be buffered before a frame starts
        if (level >= FrameLvl) begin
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (gap_ok) begin
          strobe  = 1'b1;
          data_d  = {HdrMagic, seq_q};
          addr_d  = 9'd0;
          chk_d   = 32'd0;
          idx_d   = 9'd0;
          state_d = StPay;
        end
      end
      StPay: begin
        if (gap_ok) begin
          strobe = 1'b1;
          pop    = 1'b1;
          data_d = head;
          addr_d = idx_q + 9'd1;
          chk_d  = chk_q ^ head;
          idx_d  = idx_q + 9'd1;
          if (idx_q == LastIdx) begin
            state_d = StChk;
          end
        end
      end
      StChk: begin
        if (gap_ok) begin
          strobe  = 1'b1;
          data_d  = chk_q;
          addr_d  = ChkAddr;
          seq_d   = seq_q + 16'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (strobe) begin
      gap_d = GapReload;
    end else if (gap_ok) begin
      gap_d = gap_q;
    end else begin
      gap_d = gap_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      chk_q   <= '0;
      idx_q   <= '0;
      seq_q   <= SEQ_INIT;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wr_q    <= strobe;
      chk_q   <= chk_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      gap_q   <= gap_d;
    end
  end

  assign o_data     = data_q;
  assign o_addr     = addr_q;
  assign o_wr       = wr_q;
  assign o_busy     = (state_q != StIdle);
  assign o_level    = level;
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_sample_frame_packer.sv
// Scoreboard bench for sample_frame_packer: directed pushes queue expected strobes, a negedge
// monitor pops and compares them. A second instance starts its sequence number at FFFF.
module tb_sample_frame_packer;

  localparam int unsigned FrameLen = 4;
  localparam int unsigned FifoAw   = 3;
  localparam int unsigned Gap      = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              a_valid, b_valid;
  logic [31:0]       a_sample, b_sample;
  logic [31:0]       a_data, b_data;
  logic [8:0]        a_addr, b_addr;
  logic              a_wr, b_wr, a_busy, b_busy;
  logic [FifoAw:0]   a_level, b_level;
  logic [15:0]       a_drop, b_drop;

  sample_frame_packer #(
    .FRAME_LEN (FrameLen),
    .FIFO_AW   (FifoAw),
    .GAP_CYCLES(Gap),
    .SEQ_INIT  (16'h0000)
  ) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (a_valid),
    .i_sample  (a_sample),
    .o_data    (a_data),
    .o_addr    (a_addr),
    .o_wr      (a_wr),
    .o_busy    (a_busy),
    .o_level   (a_level),
    .o_drop_cnt(a_drop)
  );

  sample_frame_packer #(
    .FRAME_LEN (FrameLen),
    .FIFO_AW   (FifoAw),
    .GAP_CYCLES(Gap),
    .SEQ_INIT  (16'hFFFF)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (b_valid),
    .i_sample  (b_sample),
    .o_data    (b_data),
    .o_addr    (b_addr),
    .o_wr      (b_wr),
    .o_busy    (b_busy),
    .o_level   (b_level),
    .o_drop_cnt(b_drop)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [8:0]  addr;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   prev_a = -1;
  int   prev_b = -1;
  int   hdr_cyc_a = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input int k, input logic [31:0] d, input logic [8:0] a);
    exp_t e;
    e.data = d;
    e.addr = a;
    if (k == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic expect_frame(input int k, input logic [15:0] seq,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
    push_exp(k, {16'hA5A5, seq}, 9'd0);
    push_exp(k, w0, 9'd1);
    push_exp(k, w1, 9'd2);
    push_exp(k, w2, 9'd3);
    push_exp(k, w3, 9'd4);
    push_exp(k, w0 ^ w1 ^ w2 ^ w3, 9'd5);
  endtask

  task automatic mon_strobe(input int k, input logic [31:0] d, input logic [8:0] a);
    exp_t e;
    int   prev;
    int   qsize;
    prev = (k == 0) ? prev_a : prev_b;
    if (prev >= 0) begin
      checks++;
      // Within a frame spacing is exact; a header may follow a longer idle period
      if ((a != 9'd0) ? (cyc - prev != Gap) : (cyc - prev < Gap)) begin
        failures++;
        $display("FAIL strobe_spacing inst=%0d addr=%0d actual=%0d required=%0d",
                 k, a, cyc - prev, Gap);
      end
    end
    if (k == 0) begin
      prev_a = cyc;
      if (a == 9'd0) hdr_cyc_a = cyc;
    end else begin
      prev_b = cyc;
    end
    qsize = (k == 0) ? qa.size() : qb.size();
    if (qsize == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_strobe inst=%0d actual=%h@%0d required=none", k, d, a);
    end else begin
      if (k == 0) e = qa.pop_front();
      else        e = qb.pop_front();
      check($sformatf("strobe_data inst=%0d", k), d, e.data);
      check($sformatf("strobe_addr inst=%0d", k), 32'(a), 32'(e.addr));
    end
  endtask

  always @(negedge clk) begin
    if (a_wr) mon_strobe(0, a_data, a_addr);
    if (b_wr) mon_strobe(1, b_data, b_addr);
  end

  task automatic push_a(input logic [31:0] v);
    a_valid  = 1'b1;
    a_sample = v;
    @(posedge clk);
    #1;
    a_valid  = 1'b0;
  endtask

  task automatic push_b(input logic [31:0] v);
    b_valid  = 1'b1;
    b_sample = v;
    @(posedge clk);
    #1;
    b_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (!(qa.size() == 0 && qb.size() == 0 && !a_busy && !b_busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, 32'(qa.size() + qb.size()), 32'd0);
  endtask

  initial begin
    int p4;
    int n;
    reset    = 1'b0;
    a_valid  = 1'b0;
    b_valid  = 1'b0;
    a_sample = '0;
    b_sample = '0;

    // 1. reset
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    check("rst_data", a_data, 32'd0);
    check("rst_addr", 32'(a_addr), 32'd0);
    check("rst_wr", 32'(a_wr), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_level", 32'(a_level), 32'd0);
    check("rst_drop", 32'(a_drop), 32'd0);
    idle(8);
    check("idle_busy", 32'(a_busy), 32'd0);

    // 2. single frame, latency from the last push to the header strobe
    expect_frame(0, 16'h0000, 32'd1, 32'd2, 32'd3, 32'd4);
    push_a(32'd1);
    push_a(32'd2);
    push_a(32'd3);
    push_a(32'd4);
    p4 = cyc;
    wait_drain("frame0", 200);
    check("hdr_latency", 32'(hdr_cyc_a - p4), 32'd2);
    check("frame0_level", 32'(a_level), 32'd0);

    // 3. two back-to-back frames
    expect_frame(0, 16'h0001, 32'hDEAD0001, 32'hBEEF0002, 32'h12345678, 32'h0F0F0F0F);
    expect_frame(0, 16'h0002, 32'hFFFFFFFF, 32'h00000001, 32'hA5A55A5A, 32'h80000000);
    push_a(32'hDEAD0001);
    push_a(32'hBEEF0002);
    push_a(32'h12345678);
    push_a(32'h0F0F0F0F);
    push_a(32'hFFFFFFFF);
    push_a(32'h00000001);
    push_a(32'hA5A55A5A);
    push_a(32'h80000000);
    wait_drain("frames12", 400);
    idle(6);

    // 4. 12-cycle burst from idle: edges 1-8 fill the FIFO, 9-10 drop (pop at 10 too late),
    //    11 refills the slot freed at 10, 12 drops again; 0x10A stays behind
    expect_frame(0, 16'h0003, 32'h100, 32'h101, 32'h102, 32'h103);
    expect_frame(0, 16'h0004, 32'h104, 32'h105, 32'h106, 32'h107);
    for (int i = 0; i < 12; i++) push_a(32'h100 + 32'(i));
    check("burst_level", 32'(a_level), 32'd8);
    check("burst_drop", 32'(a_drop), 32'd3);
    wait_drain("burst", 400);
    check("burst_left", 32'(a_level), 32'd1);
    check("burst_drop_hold", 32'(a_drop), 32'd3);

    // 5. reset after two payload strobes of a frame
    expect_frame(0, 16'h0005, 32'h10A, 32'h201, 32'h202, 32'h203);
    push_a(32'h201);
    push_a(32'h202);
    push_a(32'h203);
    n = 0;
    while (qa.size() > 3 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("pre_reset_pending", 32'(qa.size()), 32'd3);
    reset = 1'b0;
    qa.delete();
    idle(2);
    reset = 1'b1;
    check("mid_rst_level", 32'(a_level), 32'd0);
    check("mid_rst_busy", 32'(a_busy), 32'd0);
    check("mid_rst_wr", 32'(a_wr), 32'd0);
    check("mid_rst_drop", 32'(a_drop), 32'd0);
    idle(12);
    expect_frame(0, 16'h0000, 32'h301, 32'h302, 32'h303, 32'h304);
    push_a(32'h301);
    push_a(32'h302);
    push_a(32'h303);
    push_a(32'h304);
    wait_drain("post_rst", 200);

    // 6. sequence number wrap on the instance preset to FFFF
    expect_frame(1, 16'hFFFF, 32'h601, 32'h602, 32'h603, 32'h604);
    expect_frame(1, 16'h0000, 32'h605, 32'h606, 32'h607, 32'h608);
    for (int i = 1; i <= 8; i++) push_b(32'h600 + 32'(i));
    wait_drain("wrap", 400);
    check("wrap_level", 32'(b_level), 32'd0);

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
